mlp_train_sequencer: RTL and testbench

On-chip controller that drives the MLP through a full training schedule and scores the results, replacing the simulation-only stimulus loop. It issues example indices to the `Data` store, controls the MLP `training` input, and samples `prediction`/`expected` after a fixed pipeline latency. It counts correctly classified examples per evaluation pass and for the final test pass. It sits between `Data` and `MLP`, acting as the initiator that both of them respond to.

---
 rtl/mlp_train_sequencer_pkg.sv | 30 +++
 rtl/mlp_train_sequencer_scorer.sv | 48 ++++
 rtl/mlp_train_sequencer.sv | 170 +++++++++++++++++
 tb/tb_mlp_train_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_train_sequencer_pkg.sv
// Shared types for the MLP training sequencer: signed fixed-point format,
// FSM state encoding and the per-output class comparison.
package mlp_train_sequencer_pkg;

  localparam int unsigned SFP_W    = 16;
  localparam int unsigned SFP_FRAC = 8;

  typedef logic signed [SFP_W-1:0] sfp;

  localparam sfp HALF = sfp'(1 << (SFP_FRAC - 1));

  localparam logic [31:0] COUNT_MAX = 32'h7FFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    TRAIN,
    TRAIN_DRAIN,
    EVAL,
    EVAL_DRAIN,
    TEST,
    TEST_DRAIN,
    DONE
  } seq_state_e;

  // A value equal to the threshold falls in class 1 (not below).
  function automatic logic class_match(input sfp pred, input sfp lbl, input sfp thr);
    return (pred < thr) == (lbl < thr);
  endfunction

endpackage

// File: rtl/mlp_train_sequencer_scorer.sv
// Aligns tagged labels with the MLP output after the pipeline latency and
// keeps a saturating count of correctly classified examples.
module mlp_train_sequencer_scorer
  import mlp_train_sequencer_pkg::*;
#(
  parameter int unsigned outputs = 1,
  parameter int unsigned latency = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tag,
  input  logic                       clear,
  input  logic [SFP_W-1:0]           threshold,
  input  logic [outputs*SFP_W-1:0]   prediction,
  input  logic [outputs*SFP_W-1:0]   expected,
  output logic [31:0]                count_next
);

  localparam int unsigned W = outputs * SFP_W;

  // Bit W is the scoring tag, the rest is the label captured with it.
  logic [W:0]  pipe [latency];
  logic [31:0] count;
  logic        hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < latency; i++) pipe[i] <= '0;
      count <= '0;
    end else begin
      pipe[0] <= {tag, expected};
      for (int unsigned i = 1; i < latency; i++) pipe[i] <= pipe[i-1];
      count <= clear ? '0 : count_next;
    end
  end

  always_comb begin
    hit = pipe[latency-1][W];
    for (int unsigned j = 0; j < outputs; j++) begin
      if (!class_match(sfp'(prediction[j*SFP_W +: SFP_W]),
                       sfp'(pipe[latency-1][j*SFP_W +: SFP_W]),
                       sfp'(threshold)))
        hit = 1'b0;
    end
    count_next = (hit && count != COUNT_MAX) ? count + 32'd1 : count;
  end

endmodule

// File: rtl/mlp_train_sequencer.sv
// Training schedule controller: train/eval passes for each epoch, then one
// scored test pass, issuing example indices and the MLP training enable.
module mlp_train_sequencer
  import mlp_train_sequencer_pkg::*;
#(
  parameter int unsigned outputs            = 1,
  parameter int unsigned num_train_examples = 70,
  parameter int unsigned num_test_examples  = 30,
  parameter int unsigned epochs             = 100,
  parameter int unsigned latency            = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [SFP_W-1:0]         threshold,
  input  logic [outputs*SFP_W-1:0] prediction,
  input  logic [outputs*SFP_W-1:0] expected,
  output logic [31:0]              example,
  output logic                     training,
  output logic                     busy,
  output logic                     done,
  output logic [31:0]              epoch,
  output logic [31:0]              eval_correct,
  output logic [31:0]              test_correct
);

  localparam logic [31:0] LAST_TRAIN = 32'(num_train_examples - 1);
  localparam logic [31:0] FIRST_TEST = 32'(num_train_examples);
  localparam logic [31:0] LAST_TEST  = 32'(num_train_examples + num_test_examples - 1);
  localparam logic [31:0] LAT_LAST   = 32'(latency - 1);
  localparam logic [31:0] EPOCHS     = 32'(epochs);

  seq_state_e  state_q, state_d;
  logic [31:0] idx_q, idx_d;
  logic [31:0] dcnt_q, dcnt_d;
  logic [31:0] epoch_q, epoch_d;
  logic [31:0] eval_q, eval_d;
  logic [31:0] test_q, test_d;
  logic        tag;
  logic        clear;
  logic [31:0] count_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      dcnt_q  <= '0;
      epoch_q <= '0;
      eval_q  <= '0;
      test_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dcnt_q  <= dcnt_d;
      epoch_q <= epoch_d;
      eval_q  <= eval_d;
      test_q  <= test_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dcnt_d  = dcnt_q;
    epoch_d = epoch_q;
    eval_d  = eval_q;
    test_d  = test_q;
    tag     = 1'b0;
    clear   = 1'b0;
    unique case (state_q)
      IDLE: begin
        idx_d = '0;
        if (start) begin
          state_d = TRAIN;
          epoch_d = '0;
          eval_d  = '0;
          test_d  = '0;
          clear   = 1'b1;
        end
      end
      TRAIN: begin
        if (idx_q == LAST_TRAIN) begin
          state_d = TRAIN_DRAIN;
          dcnt_d  = '0;
        end else begin
          idx_d = idx_q + 32'd1;
        end
      end
      TRAIN_DRAIN: begin
        if (dcnt_q == LAT_LAST) begin
          state_d = EVAL;
          idx_d   = '0;
        end else begin
          dcnt_d = dcnt_q + 32'd1;
        end
      end
      EVAL: begin
        tag = 1'b1;
        if (idx_q == LAST_TRAIN) begin
          state_d = EVAL_DRAIN;
          dcnt_d  = '0;
        end else begin
          idx_d = idx_q + 32'd1;
        end
      end
      EVAL_DRAIN: begin
        if (dcnt_q == LAT_LAST) begin
          // count_next includes the final comparison landing in this cycle.
          eval_d  = count_next;
          clear   = 1'b1;
          epoch_d = epoch_q + 32'd1;
          if (epoch_d < EPOCHS) begin
            state_d = TRAIN;
            idx_d   = '0;
          end else begin
            state_d = TEST;
            idx_d   = FIRST_TEST;
          end
        end else begin
          dcnt_d = dcnt_q + 32'd1;
        end
      end
      TEST: begin
        tag = 1'b1;
        if (idx_q == LAST_TEST) begin
          state_d = TEST_DRAIN;
          dcnt_d  = '0;
        end else begin
          idx_d = idx_q + 32'd1;
        end
      end
      TEST_DRAIN: begin
        if (dcnt_q == LAT_LAST) begin
          test_d  = count_next;
          state_d = DONE;
        end else begin
          dcnt_d = dcnt_q + 32'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  mlp_train_sequencer_scorer #(
    .outputs (outputs),
    .latency (latency)
  ) u_scorer (
    .clk        (clk),
    .rst        (rst),
    .tag        (tag),
    .clear      (clear),
    .threshold  (threshold),
    .prediction (prediction),
    .expected   (expected),
    .count_next (count_next)
  );

  assign example      = idx_q;
  assign training     = (state_q == TRAIN) || (state_q == TRAIN_DRAIN);
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign epoch        = epoch_q;
  assign eval_correct = eval_q;
  assign test_correct = test_q;

endmodule

// File: tb/tb_mlp_train_sequencer.sv
// Bench: two sequencers (2 outputs / latency 1, 1 output / latency 3) driven by
// table-based Data/MLP stubs; scores are predicted from the tables directly.
module tb_mlp_train_sequencer;

  localparam logic [15:0] THR = 16'd128;
  localparam logic [15:0] ONE = 16'd256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start;
  logic [15:0] threshold;

  logic [31:0] pred_a, exp_a, example_a, epoch_a, evc_a, tsc_a;
  logic        training_a, busy_a, done_a;
  logic [15:0] pred_b, exp_b;
  logic [31:0] example_b, epoch_b, evc_b, tsc_b;
  logic        training_b, busy_b, done_b;

  logic [31:0] pa [8];
  logic [31:0] ea [8];
  logic [15:0] pb [8];
  logic [15:0] eb [8];
  logic [2:0]  hb [3];

  int total = 0;
  int passed = 0;

  mlp_train_sequencer #(
    .outputs(2), .num_train_examples(4), .num_test_examples(2), .epochs(2), .latency(1)
  ) u_a (
    .clk(clk), .rst(rst), .start(start), .threshold(threshold),
    .prediction(pred_a), .expected(exp_a), .example(example_a),
    .training(training_a), .busy(busy_a), .done(done_a), .epoch(epoch_a),
    .eval_correct(evc_a), .test_correct(tsc_a)
  );

  mlp_train_sequencer #(
    .outputs(1), .num_train_examples(4), .num_test_examples(2), .epochs(2), .latency(3)
  ) u_b (
    .clk(clk), .rst(rst), .start(start), .threshold(threshold),
    .prediction(pred_b), .expected(exp_b), .example(example_b),
    .training(training_b), .busy(busy_b), .done(done_b), .epoch(epoch_b),
    .eval_correct(evc_b), .test_correct(tsc_b)
  );

  // Data stubs answer in the same cycle; MLP stubs answer `latency` cycles later.
  always_comb exp_a = ea[example_a[2:0]];
  always_comb exp_b = eb[example_b[2:0]];
  always @(posedge clk) pred_a <= pa[example_a[2:0]];
  always @(posedge clk) begin
    hb[0] <= example_b[2:0];
    hb[1] <= hb[0];
    hb[2] <= hb[1];
  end
  always_comb pred_b = pb[hb[2]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  function automatic bit below(input logic [15:0] v);
    return $signed(v) < $signed(threshold);
  endfunction

  function automatic int score_a(input int lo, input int n);
    int s = 0;
    for (int i = lo; i < lo + n; i++)
      if (below(pa[i][15:0]) == below(ea[i][15:0]) && below(pa[i][31:16]) == below(ea[i][31:16]))
        s++;
    return s;
  endfunction

  function automatic int score_b(input int lo, input int n);
    int s = 0;
    for (int i = lo; i < lo + n; i++)
      if (below(pb[i]) == below(eb[i])) s++;
    return s;
  endfunction

  function automatic logic [15:0] rnd16();
    int v;
    v = int'($urandom_range(0, 767)) - 384;
    if ($urandom_range(0, 3) == 0) v = int'(THR);
    return 16'(v);
  endfunction

  function automatic logic [15:0] label01();
    return ($urandom_range(0, 1) == 1) ? ONE : 16'h0000;
  endfunction

  // 0 identity, 1 inverted labels, 2 independent random, 3 one mismatch, 4 at threshold
  task automatic fill(input int mode);
    for (int i = 0; i < 8; i++) begin
      case (mode)
        0: begin
          ea[i] = {rnd16(), rnd16()}; pa[i] = ea[i];
          eb[i] = rnd16(); pb[i] = eb[i];
        end
        1: begin
          ea[i] = {label01(), label01()};
          pa[i] = {ONE - ea[i][31:16], ONE - ea[i][15:0]};
          eb[i] = label01(); pb[i] = ONE - eb[i];
        end
        2: begin
          ea[i] = {rnd16(), rnd16()}; pa[i] = {rnd16(), rnd16()};
          eb[i] = rnd16(); pb[i] = rnd16();
        end
        3: begin
          ea[i] = {rnd16(), rnd16()}; pa[i] = ea[i];
          eb[i] = rnd16(); pb[i] = eb[i];
        end
        default: begin
          ea[i] = {ONE, ONE}; pa[i] = {THR, THR};
          eb[i] = ONE; pb[i] = THR;
        end
      endcase
    end
    if (mode == 3) begin
      ea[2][31:16] = 16'h0000;
      pa[2][31:16] = ONE;
    end
  endtask

  task automatic run(input int rst_at, input int poke_at, output int da, output int db);
    int c;
    da = -1;
    db = -1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c = 1;
    chk("first_example_a", example_a, 0);
    chk("first_training_a", {31'd0, training_a}, 1);
    chk("first_busy_b", {31'd0, busy_b}, 1);
    chk("first_training_b", {31'd0, training_b}, 1);
    while (c < 100) begin
      if (done_a && da < 0) da = c;
      if (done_b && db < 0) db = c;
      if (da >= 0 && c == da + 1) begin
        chk("done_a_pulse", {31'd0, done_a}, 0);
        chk("idle_busy_a", {31'd0, busy_a}, 0);
      end
      if (db >= 0) break;
      if (c == poke_at) start = 1'b1;
      if (c == rst_at) rst = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      rst = 1'b0;
      c++;
      if (c == rst_at + 1) begin
        chk("rst_example_a", example_a, 0);
        chk("rst_training_a", {31'd0, training_a}, 0);
        chk("rst_busy_a", {31'd0, busy_a}, 0);
        chk("rst_epoch_a", epoch_a, 0);
        chk("rst_eval_a", evc_a, 0);
        chk("rst_busy_b", {31'd0, busy_b}, 0);
        chk("rst_example_b", example_b, 0);
        chk("rst_epoch_b", epoch_b, 0);
        return;
      end
    end
    if (db >= 0) begin
      @(posedge clk); #1;
      chk("done_b_pulse", {31'd0, done_b}, 0);
      chk("idle_busy_b", {31'd0, busy_b}, 0);
    end
  endtask

  task automatic check_results(input string tag, input int da, input int db);
    chk({tag, "_done_cycle_a"}, da, 24);
    chk({tag, "_done_cycle_b"}, db, 34);
    chk({tag, "_epoch_a"}, epoch_a, 2);
    chk({tag, "_epoch_b"}, epoch_b, 2);
    chk({tag, "_eval_a"}, evc_a, 32'(score_a(0, 4)));
    chk({tag, "_test_a"}, tsc_a, 32'(score_a(4, 2)));
    chk({tag, "_eval_b"}, evc_b, 32'(score_b(0, 4)));
    chk({tag, "_test_b"}, tsc_b, 32'(score_b(4, 2)));
  endtask

  initial begin
    int da, db;
    rst = 1'b1;
    start = 1'b0;
    threshold = THR;
    fill(0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_example_a", example_a, 0);
    chk("reset_training_a", {31'd0, training_a}, 0);
    chk("reset_busy_a", {31'd0, busy_a}, 0);
    chk("reset_done_a", {31'd0, done_a}, 0);
    chk("reset_epoch_a", epoch_a, 0);
    chk("reset_eval_a", evc_a, 0);
    chk("reset_test_a", tsc_a, 0);
    chk("reset_busy_b", {31'd0, busy_b}, 0);
    chk("reset_test_b", tsc_b, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy_a", {31'd0, busy_a}, 0);

    fill(0);
    run(-1, -1, da, db);
    check_results("identity", da, db);
    chk("identity_eval_all_a", evc_a, 4);
    chk("identity_test_all_b", tsc_b, 2);

    fill(1);
    run(-1, -1, da, db);
    check_results("inverted", da, db);
    chk("inverted_eval_zero_a", evc_a, 0);
    chk("inverted_test_zero_b", tsc_b, 0);

    for (int k = 0; k < 3; k++) begin
      fill(2);
      run(-1, -1, da, db);
      check_results("random", da, db);
    end

    fill(3);
    run(-1, -1, da, db);
    check_results("one_miss", da, db);
    chk("one_miss_eval_a", evc_a, 3);
    chk("one_miss_test_a", tsc_a, 2);

    fill(4);
    run(-1, -1, da, db);
    check_results("at_thr", da, db);
    chk("at_thr_eval_b", evc_b, 4);

    fill(2);
    run(18, -1, da, db);
    repeat (2) @(posedge clk);
    #1;
    run(-1, -1, da, db);
    check_results("after_rst", da, db);

    fill(2);
    run(-1, 12, da, db);
    check_results("poke_busy", da, db);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
